// File: rtl/dither_scan_ctrl_if.sv
// MCU pixel handshakes: tx carries pixels into the FPGA, rx carries results back out.
// master = MCU side, slave = dither_scan_ctrl side.
interface dither_scan_ctrl_if;
    logic mcu_tx_valid;
    logic mcu_tx_ready;
    logic mcu_rx_valid;
    logic mcu_rx_ready;

    modport master (
        output mcu_tx_valid,
        input  mcu_tx_ready,
        input  mcu_rx_valid,
        output mcu_rx_ready
    );

    modport slave (
        input  mcu_tx_valid,
        output mcu_tx_ready,
        output mcu_rx_valid,
        input  mcu_rx_ready
    );
endinterface

// File: rtl/dither_scan_ctrl.sv
// Scan controller for an error-diffusion dither engine: load from MCU, 6-cycle compute per pixel-channel, unload.
// Optional macro DITHER_SERPENTINE_EN: odd rows are scanned right-to-left during compute.
module dither_scan_ctrl #(
    parameter int  IMAGEX   = 64,
    parameter int  IMAGEY   = 64,
    parameter int  CHANNELS = 1,
    localparam int ADDR_W   = $clog2(IMAGEX * IMAGEY),
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    dither_scan_ctrl_if.slave  mcu,
    output logic [ADDR_W-1:0]  pix_addr,
    output logic [CH_W-1:0]    chan,
    output logic               rden_a,
    output logic               rden_b,
    output logic               wren_a,
    output logic               wren_b,
    output logic               store_old_p,
    output logic               quant_en,
    output logic [3:0]         err_step,
    output logic               at_left,
    output logic               at_right,
    output logic               at_bottom,
    output logic               scan_dir,
    output logic               busy,
    output logic               done,
    output logic [3:0]         state
);
    localparam int X_W = $clog2(IMAGEX);
    localparam int Y_W = $clog2(IMAGEY);
    localparam logic [X_W-1:0]  X_MAX  = X_W'(IMAGEX - 1);
    localparam logic [Y_W-1:0]  Y_MAX  = Y_W'(IMAGEY - 1);
    localparam logic [CH_W-1:0] CH_MAX = CH_W'(CHANNELS - 1);

`ifdef DITHER_SERPENTINE_EN
    localparam logic SERPENTINE = 1'b1;
`else
    localparam logic SERPENTINE = 1'b0;
`endif

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        LOAD   = 4'd1,
        RD_OLD = 4'd2,
        QUANT  = 4'd3,
        E_RD0  = 4'd4,
        E_WR0  = 4'd5,
        E_RD1  = 4'd6,
        E_WR1  = 4'd7,
        U_RD   = 4'd8,
        U_SEND = 4'd9,
        DONE   = 4'd10
    } state_t;

    localparam state_t ERR_ST [4] = '{E_RD0, E_WR0, E_RD1, E_WR1};

    state_t          state_q, state_d;
    logic [X_W-1:0]  x_q, x_d;
    logic [Y_W-1:0]  y_q, y_d;
    logic [CH_W-1:0] ch_q, ch_d;

    logic [ADDR_W-1:0] pix_addr_q;
    logic [CH_W-1:0]   chan_q;
    logic rden_a_q, rden_b_q, wren_a_q, wren_b_q;
    logic store_old_q, quant_en_q;
    logic [3:0] err_step_q, err_step_d;
    logic at_left_q, at_right_q, at_bottom_q, scan_dir_q;
    logic busy_q, done_q, tx_ready_q, rx_valid_q;

    // Raster successor (channel innermost), shared by load and unload.
    logic [X_W-1:0]  rs_x;
    logic [Y_W-1:0]  rs_y;
    logic [CH_W-1:0] rs_ch;
    logic            raster_last;

    always_comb begin
        rs_x  = x_q;
        rs_y  = y_q;
        rs_ch = ch_q;
        if (ch_q != CH_MAX) begin
            rs_ch = ch_q + 1'b1;
        end else begin
            rs_ch = '0;
            if (x_q != X_MAX) begin
                rs_x = x_q + 1'b1;
            end else begin
                rs_x = '0;
                rs_y = y_q + 1'b1;
            end
        end
    end

    assign raster_last = (ch_q == CH_MAX) && (x_q == X_MAX) && (y_q == Y_MAX);

    logic rev_q, rev_next_row, row_end, cmp_d;
    logic [Y_W-1:0] y_inc;

    assign y_inc        = y_q + 1'b1;
    assign rev_q        = SERPENTINE & y_q[0];
    assign rev_next_row = SERPENTINE & y_inc[0];
    assign row_end      = rev_q ? (x_q == '0) : (x_q == X_MAX);
    assign cmp_d        = (state_d inside {RD_OLD, QUANT, E_RD0, E_WR0, E_RD1, E_WR1});

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        ch_d    = ch_q;
        case (state_q)
            IDLE: if (start) state_d = LOAD;
            LOAD: begin
                if (mcu.mcu_tx_valid) begin
                    if (raster_last) begin
                        state_d = RD_OLD;
                        x_d = '0;
                        y_d = '0;
                        ch_d = '0;
                    end else begin
                        x_d = rs_x;
                        y_d = rs_y;
                        ch_d = rs_ch;
                    end
                end
            end
            RD_OLD: state_d = QUANT;
            QUANT:  state_d = E_RD0;
            E_RD0:  state_d = E_WR0;
            E_WR0:  state_d = E_RD1;
            E_RD1:  state_d = E_WR1;
            E_WR1: begin
                state_d = RD_OLD;
                if (ch_q != CH_MAX) begin
                    ch_d = ch_q + 1'b1;
                end else begin
                    ch_d = '0;
                    if (!row_end) begin
                        x_d = rev_q ? (x_q - 1'b1) : (x_q + 1'b1);
                    end else if (y_q == Y_MAX) begin
                        state_d = U_RD;
                        x_d = '0;
                        y_d = '0;
                    end else begin
                        y_d = y_inc;
                        x_d = rev_next_row ? X_MAX : '0;
                    end
                end
            end
            U_RD: state_d = U_SEND;
            U_SEND: begin
                if (mcu.mcu_rx_ready) begin
                    if (raster_last) begin
                        state_d = DONE;
                        x_d = '0;
                        y_d = '0;
                        ch_d = '0;
                    end else begin
                        state_d = U_RD;
                        x_d = rs_x;
                        y_d = rs_y;
                        ch_d = rs_ch;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_err_step
        assign err_step_d[gi] = (state_d == ERR_ST[gi]);
    end

    // Outputs are registered from the next-state decode so they line up with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            ch_q        <= '0;
            pix_addr_q  <= '0;
            chan_q      <= '0;
            rden_a_q    <= 1'b0;
            rden_b_q    <= 1'b0;
            wren_a_q    <= 1'b0;
            wren_b_q    <= 1'b0;
            store_old_q <= 1'b0;
            quant_en_q  <= 1'b0;
            err_step_q  <= '0;
            at_left_q   <= 1'b0;
            at_right_q  <= 1'b0;
            at_bottom_q <= 1'b0;
            scan_dir_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tx_ready_q  <= 1'b0;
            rx_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            ch_q        <= ch_d;
            pix_addr_q  <= ADDR_W'(y_d) * ADDR_W'(IMAGEX) + ADDR_W'(x_d);
            chan_q      <= ch_d;
            rden_a_q    <= (state_d inside {RD_OLD, E_RD0, E_RD1, U_RD});
            rden_b_q    <= (state_d inside {E_RD0, E_RD1});
            wren_a_q    <= (state_d inside {QUANT, E_WR0, E_WR1});
            wren_b_q    <= (state_d inside {E_WR0, E_WR1});
            store_old_q <= (state_d == RD_OLD);
            quant_en_q  <= (state_d == QUANT);
            err_step_q  <= err_step_d;
            at_left_q   <= cmp_d && (x_d == '0);
            at_right_q  <= cmp_d && (x_d == X_MAX);
            at_bottom_q <= cmp_d && (y_d == Y_MAX);
            scan_dir_q  <= cmp_d && SERPENTINE && y_d[0];
            busy_q      <= !(state_d inside {IDLE, DONE});
            done_q      <= (state_d == DONE);
            tx_ready_q  <= (state_d == LOAD);
            rx_valid_q  <= (state_d == U_SEND);
        end
    end

    // A load beat writes in the same cycle the pixel is presented.
    assign wren_a = wren_a_q | (tx_ready_q & mcu.mcu_tx_valid & ~rst);

    assign pix_addr         = pix_addr_q;
    assign chan             = chan_q;
    assign rden_a           = rden_a_q;
    assign rden_b           = rden_b_q;
    assign wren_b           = wren_b_q;
    assign store_old_p      = store_old_q;
    assign quant_en         = quant_en_q;
    assign err_step         = err_step_q;
    assign at_left          = at_left_q;
    assign at_right         = at_right_q;
    assign at_bottom        = at_bottom_q;
    assign scan_dir         = scan_dir_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign state            = state_q;
    assign mcu.mcu_tx_ready = tx_ready_q;
    assign mcu.mcu_rx_valid = rx_valid_q;
endmodule

// File: tb/tb_dither_scan_ctrl.sv
// Randomized bench for dither_scan_ctrl (4x2 image, 3 channels) against a loop-based scan-order model.
module tb_dither_scan_ctrl;
    localparam int IX = 4, IY = 2, CH = 3, N = IX * IY * CH;
    localparam int AW = 3, CW = 2;

`ifdef DITHER_SERPENTINE_EN
    localparam bit SERP = 1'b1;
`else
    localparam bit SERP = 1'b0;
`endif

    // State numbers follow the listed state order: IDLE=0, LOAD=1, RD_OLD=2 .. E_WR1=7, U_RD=8, U_SEND=9, DONE=10.
    // Per compute phase: {rden_a, rden_b, wren_a, wren_b, store_old_p, quant_en, err_step}.
    localparam logic [9:0] PH_STROBES [6] = '{
        10'b100010_0000, 10'b001001_0000, 10'b110000_0001,
        10'b001100_0010, 10'b110000_0100, 10'b001100_1000
    };

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [AW-1:0] pix_addr;
    logic [CW-1:0] chan;
    logic rden_a, rden_b, wren_a, wren_b, store_old_p, quant_en;
    logic [3:0] err_step, state;
    logic at_left, at_right, at_bottom, scan_dir, busy, done;

    dither_scan_ctrl_if mcu ();

    dither_scan_ctrl #(.IMAGEX(IX), .IMAGEY(IY), .CHANNELS(CH)) dut (
        .clk(clk), .rst(rst), .start(start), .mcu(mcu),
        .pix_addr(pix_addr), .chan(chan),
        .rden_a(rden_a), .rden_b(rden_b), .wren_a(wren_a), .wren_b(wren_b),
        .store_old_p(store_old_p), .quant_en(quant_en), .err_step(err_step),
        .at_left(at_left), .at_right(at_right), .at_bottom(at_bottom),
        .scan_dir(scan_dir), .busy(busy), .done(done), .state(state)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, jobs = 0, done_seen = 0;

    always @(negedge clk) if (done === 1'b1) done_seen++;

    logic [26:0] all_outs;
    assign all_outs = {mcu.mcu_tx_ready, mcu.mcu_rx_valid, pix_addr, chan, rden_a, rden_b,
                       wren_a, wren_b, store_old_p, quant_en, err_step, at_left, at_right,
                       at_bottom, scan_dir, busy, done, state};

    typedef struct {
        int addr;
        int ch;
        bit dir;
        bit left;
        bit right;
        bit bottom;
    } elem_t;
    elem_t cmp_order[$];

    function automatic void build_compute_order();
        elem_t e;
        cmp_order.delete();
        for (int y = 0; y < IY; y++) begin
            for (int i = 0; i < IX; i++) begin
                bit rev;
                int x;
                rev = SERP && (y % 2 == 1);
                x = rev ? (IX - 1 - i) : i;
                for (int c = 0; c < CH; c++) begin
                    e.addr = y * IX + x;
                    e.ch = c;
                    e.dir = rev;
                    e.left = (x == 0);
                    e.right = (x == IX - 1);
                    e.bottom = (y == IY - 1);
                    cmp_order.push_back(e);
                end
            end
        end
    endfunction

    task automatic test_reset();
        start = 1'b1;
        mcu.mcu_tx_valid = 1'b1;
        mcu.mcu_rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (all_outs !== '0) begin
            bad++;
            $display("FAIL reset_zero got=%b want=0", all_outs);
        end
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        mcu.mcu_tx_valid = 1'b0;
        mcu.mcu_rx_ready = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if (all_outs !== '0) begin
            bad++;
            $display("FAIL idle_hold got=%b want=0", all_outs);
        end
    endtask

    task automatic test_load(input bit b2b);
        logic [9:0] obs, exp;
        int gaps;
        @(negedge clk);
        start = 1'b1;
        mcu.mcu_tx_valid = 1'b0;
        mcu.mcu_rx_ready = 1'($urandom);
        #1;
        total++;
        if ({state, busy} !== {4'd0, 1'b0}) begin
            bad++;
            $display("FAIL idle_before_start state=%0d busy=%b want state=0 busy=0", state, busy);
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        total++;
        if ({state, mcu.mcu_tx_ready, wren_a, pix_addr} !== {4'd1, 1'b1, 1'b0, 3'd0}) begin
            bad++;
            $display("FAIL load_entry state=%0d ready=%b wren_a=%b addr=%0d want 1/1/0/0",
                     state, mcu.mcu_tx_ready, wren_a, pix_addr);
        end
        for (int k = 0; k < N; k++) begin
            gaps = b2b ? 0 : int'($urandom_range(0, 2));
            repeat (gaps) begin
                @(negedge clk);
                mcu.mcu_tx_valid = 1'b0;
                start = 1'($urandom);
                mcu.mcu_rx_ready = 1'($urandom);
                #1;
                total++;
                if ({state, mcu.mcu_tx_ready, wren_a, busy} !== {4'd1, 1'b1, 1'b0, 1'b1}) begin
                    bad++;
                    $display("FAIL load_gap k=%0d state=%0d ready=%b wren_a=%b busy=%b want 1/1/0/1",
                             k, state, mcu.mcu_tx_ready, wren_a, busy);
                end
            end
            @(negedge clk);
            mcu.mcu_tx_valid = 1'b1;
            start = 1'($urandom);
            mcu.mcu_rx_ready = 1'($urandom);
            #1;
            obs = {state, mcu.mcu_tx_ready, wren_a, rden_a, wren_b, rden_b, pix_addr, chan};
            exp = {4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, AW'(k / CH), CW'(k % CH)};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL load_beat k=%0d got=%b want=%b", k, obs, exp);
            end
            $display("load beat %0d addr=%0d chan=%0d", k, pix_addr, chan);
        end
    endtask

    task automatic test_compute(input bit abort_mid);
        logic [13:0] obs, exp;
        logic [12:0] obs2, exp2;
        elem_t e;
        for (int pc = 0; pc < N; pc++) begin
            e = cmp_order[pc];
            for (int ph = 0; ph < 6; ph++) begin
                @(negedge clk);
                mcu.mcu_tx_valid = 1'($urandom);
                mcu.mcu_rx_ready = 1'($urandom);
                start = 1'($urandom);
                #1;
                obs = {state, rden_a, rden_b, wren_a, wren_b, store_old_p, quant_en, err_step};
                exp = {4'(ph + 2), PH_STROBES[ph]};
                total++;
                if (obs !== exp) begin
                    bad++;
                    $display("FAIL cmp_strobes pc=%0d ph=%0d got=%b want=%b", pc, ph, obs, exp);
                end
                obs2 = {pix_addr, chan, scan_dir, at_left, at_right, at_bottom, busy,
                        mcu.mcu_tx_ready, mcu.mcu_rx_valid, done};
                exp2 = {AW'(e.addr), CW'(e.ch), e.dir, e.left, e.right, e.bottom, 1'b1, 3'b000};
                total++;
                if (obs2 !== exp2) begin
                    bad++;
                    $display("FAIL cmp_scan pc=%0d ph=%0d got=%b want=%b", pc, ph, obs2, exp2);
                end
                if (abort_mid && e.addr == 3 && e.ch == 0 && ph == 4) begin
                    rst = 1'b1;
                    return;
                end
            end
            $display("compute pc %0d addr=%0d chan=%0d dir=%b", pc, e.addr, e.ch, e.dir);
        end
    endtask

    task automatic test_unload();
        logic [12:0] obs, exp;
        logic [10:0] obs2, exp2;
        int stalls;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            start = 1'($urandom);
            mcu.mcu_tx_valid = 1'($urandom);
            mcu.mcu_rx_ready = 1'($urandom);
            #1;
            obs = {state, rden_a, rden_b, wren_a, wren_b, mcu.mcu_rx_valid, pix_addr, chan};
            exp = {4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, AW'(k / CH), CW'(k % CH)};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL unload_rd k=%0d got=%b want=%b", k, obs, exp);
            end
            stalls = (k == 2) ? 5 : int'($urandom_range(0, 2));
            for (int s = 0; s <= stalls; s++) begin
                @(negedge clk);
                mcu.mcu_rx_ready = (s == stalls);
                start = 1'($urandom);
                mcu.mcu_tx_valid = 1'($urandom);
                #1;
                obs2 = {state, mcu.mcu_rx_valid, rden_a, wren_a, pix_addr, chan};
                exp2 = {4'd9, 1'b1, 1'b0, 1'b0, AW'(k / CH), CW'(k % CH)};
                total++;
                if (obs2 !== exp2) begin
                    bad++;
                    $display("FAIL unload_send k=%0d s=%0d got=%b want=%b", k, s, obs2, exp2);
                end
            end
            $display("unload elem %0d addr=%0d chan=%0d stalls=%0d", k, pix_addr, chan, stalls);
        end
        @(negedge clk);
        start = 1'b0;
        mcu.mcu_tx_valid = 1'b0;
        mcu.mcu_rx_ready = 1'b0;
        #1;
        total++;
        if ({state, done, busy, rden_a} !== {4'd10, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL done_pulse state=%0d done=%b busy=%b want state=10 done=1 busy=0",
                     state, done, busy);
        end
        @(negedge clk);
        #1;
        total++;
        if (all_outs !== '0) begin
            bad++;
            $display("FAIL back_idle got=%b want=0", all_outs);
        end
        total++;
        if (done_seen !== jobs) begin
            bad++;
            $display("FAIL done_count got=%0d want=%0d", done_seen, jobs);
        end
    endtask

    task automatic test_full_job(input bit b2b);
        jobs++;
        test_load(b2b);
        test_compute(1'b0);
        test_unload();
    endtask

    task automatic test_back_to_back();
        test_full_job(1'b1);
        test_full_job(1'b1);
    endtask

    task automatic test_reset_mid();
        test_load(1'b1);
        test_compute(1'b1);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        mcu.mcu_tx_valid = 1'b0;
        mcu.mcu_rx_ready = 1'b0;
        #1;
        total++;
        if (all_outs !== '0) begin
            bad++;
            $display("FAIL rst_mid_zero got=%b want=0", all_outs);
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        total++;
        if ({state, mcu.mcu_tx_ready, pix_addr, chan, wren_a} !== {4'd1, 1'b1, 3'd0, 2'd0, 1'b0}) begin
            bad++;
            $display("FAIL restart_load state=%0d ready=%b addr=%0d chan=%0d want 1/1/0/0",
                     state, mcu.mcu_tx_ready, pix_addr, chan);
        end
        total++;
        if (done_seen !== jobs) begin
            bad++;
            $display("FAIL done_after_abort got=%0d want=%0d", done_seen, jobs);
        end
    endtask

    initial begin
        mcu.mcu_tx_valid = 1'b0;
        mcu.mcu_rx_ready = 1'b0;
        build_compute_order();
        test_reset();
        test_full_job(1'b0);
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout bench did not finish within 500000 time units");
        $fatal(1, "timeout");
    end
endmodule
